// File: rtl/clk_mode_sequencer.sv
// -----------------------------------------------------------------------------
// clk_mode_sequencer
//
// Purpose:
//   Steps a clock generator through NUM_MODES configurations, one step per
//   debounced button press. Each step is handed to an external configuration
//   engine through a req/ack/done handshake. One press is queued while a
//   configuration is in flight; further presses are dropped and flagged.
//   Failed or timed-out configurations raise a sticky error flag for display.
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   press          in   one-cycle press pulse from the debouncer
//   cfg_req        out  configuration request, held until acknowledged
//   cfg_mode       out  mode being requested, stable while cfg_req=1
//   cfg_ack        in   engine accepted the request
//   cfg_done       in   one-cycle completion pulse from the engine
//   cfg_fail       in   qualifies cfg_done, 1 = configuration failed
//   active_mode    out  last successfully configured mode
//   busy           out  request outstanding (REQ or WAIT)
//   cfg_error      out  sticky failure/timeout flag, cleared by a success
//   press_dropped  out  one-cycle pulse when a press is discarded
// -----------------------------------------------------------------------------
module clk_mode_sequencer #(
   parameter int NUM_MODES      = 4,
   parameter int MODE_W         = 2,
   parameter int START_MODE     = 0,
   parameter bit INIT_ON_RESET  = 1'b1,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              press,
   output logic              cfg_req,
   output logic [MODE_W-1:0] cfg_mode,
   input  logic              cfg_ack,
   input  logic              cfg_done,
   input  logic              cfg_fail,
   output logic [MODE_W-1:0] active_mode,
   output logic              busy,
   output logic              cfg_error,
   output logic              press_dropped
);

   localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [MODE_W-1:0] START_M = MODE_W'(START_MODE);
   localparam logic [MODE_W-1:0] LAST_M  = MODE_W'(NUM_MODES - 1);
   localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              init_q, init_d;        // START_MODE request still owed after reset
   logic              pending_q, pending_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [MODE_W-1:0] mode_q, mode_d;
   logic [MODE_W-1:0] active_q, active_d;
   logic              error_q, error_d;
   logic              dropped_q, dropped_d;
   logic              req_q;
   logic              busy_q;

   logic              launch;
   logic [MODE_W-1:0] launch_mode;
   logic              complete;

   // Modulo-NUM_MODES increment; never produces an index >= NUM_MODES.
   function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
      return (m == LAST_M) ? '0 : m + MODE_W'(1);
   endfunction

   always_comb begin
      state_d     = state_q;
      init_d      = init_q;
      pending_d   = pending_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      active_d    = active_q;
      error_d     = error_q;
      dropped_d   = 1'b0;
      launch      = 1'b0;
      launch_mode = mode_q;
      complete    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (init_q) begin
               launch      = 1'b1;
               launch_mode = START_M;
               init_d      = 1'b0;
               pending_d   = press;
            end else if (press) begin
               launch      = 1'b1;
               launch_mode = next_mode(active_q);
            end
         end

         S_REQ, S_WAIT: begin
            // A done pulse in REQ only counts when it arrives together with ack.
            complete = cfg_done && ((state_q == S_WAIT) || cfg_ack);
            if (complete) begin
               if (cfg_fail) begin
                  error_d   = 1'b1;
                  pending_d = 1'b0;
                  state_d   = S_IDLE;
               end else begin
                  active_d = mode_q;
                  error_d  = 1'b0;
                  // A queued press (or one arriving right now) relaunches with
                  // no IDLE cycle in between.
                  if (pending_q) begin
                     launch      = 1'b1;
                     launch_mode = next_mode(mode_q);
                     pending_d   = press;
                  end else if (press) begin
                     launch      = 1'b1;
                     launch_mode = next_mode(mode_q);
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end else if (cnt_q == TO_LAST) begin
               error_d   = 1'b1;
               pending_d = 1'b0;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if ((state_q == S_REQ) && cfg_ack) begin
                  state_d = S_WAIT;
               end
               if (press) begin
                  if (pending_q) begin
                     dropped_d = 1'b1;
                  end else begin
                     pending_d = 1'b1;
                  end
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      if (launch) begin
         state_d = S_REQ;
         mode_d  = launch_mode;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         init_q    <= INIT_ON_RESET;
         pending_q <= 1'b0;
         cnt_q     <= '0;
         mode_q    <= START_M;
         active_q  <= START_M;
         error_q   <= 1'b0;
         dropped_q <= 1'b0;
         req_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         init_q    <= init_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         mode_q    <= mode_d;
         active_q  <= active_d;
         error_q   <= error_d;
         dropped_q <= dropped_d;
         // Status outputs are registered copies of the next state.
         req_q     <= (state_d == S_REQ);
         busy_q    <= (state_d != S_IDLE);
      end
   end

   assign cfg_req       = req_q;
   assign cfg_mode      = mode_q;
   assign active_mode   = active_q;
   assign busy          = busy_q;
   assign cfg_error     = error_q;
   assign press_dropped = dropped_q;

endmodule

// File: tb/tb_clk_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_clk_mode_sequencer
//
// Purpose:
//   Self-checking bench for clk_mode_sequencer (NUM_MODES=3, TIMEOUT_CYCLES=16,
//   INIT_ON_RESET=1, START_MODE=0). Expected request modes are queued when the
//   press that causes them is driven and compared when the request appears.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_clk_mode_sequencer;

   localparam int NM = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       press = 1'b0;
   logic       cfg_req;
   logic [1:0] cfg_mode;
   logic       cfg_ack = 1'b0;
   logic       cfg_done = 1'b0;
   logic       cfg_fail = 1'b0;
   logic [1:0] active_mode;
   logic       busy;
   logic       cfg_error;
   logic       press_dropped;

   int n_checks = 0;
   int n_errors = 0;
   int exp_q[$];
   int m_active = 0;
   int drop_cnt = 0;
   int drop_base;
   bit prev_req = 1'b0;

   clk_mode_sequencer #(
      .NUM_MODES(3),
      .MODE_W(2),
      .START_MODE(0),
      .INIT_ON_RESET(1'b1),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .press(press),
      .cfg_req(cfg_req),
      .cfg_mode(cfg_mode),
      .cfg_ack(cfg_ack),
      .cfg_done(cfg_done),
      .cfg_fail(cfg_fail),
      .active_mode(active_mode),
      .busy(busy),
      .cfg_error(cfg_error),
      .press_dropped(press_dropped)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int nxt(input int m);
      return (m == NM - 1) ? 0 : m + 1;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard: every new request must match the oldest queued mode.
   always @(negedge clk) begin
      if (!reset) begin
         if (cfg_req && !prev_req) begin
            if (exp_q.size() == 0) begin
               chk_eq("req_unexpected", int'(cfg_req), 0);
            end else begin
               chk_eq("req_mode", int'(cfg_mode), exp_q.pop_front());
            end
         end
         if (press_dropped) drop_cnt++;
      end
      prev_req = cfg_req;
   end

   // One full handshake for the request currently in REQ.
   task automatic serve(input int ack_dly, input int done_dly, input bit fail, input int exp_mode);
      int n = 0;
      while (!cfg_req && n < 40) begin
         tick(1);
         n++;
      end
      chk_eq("serve_req_seen", int'(cfg_req), 1);
      repeat (ack_dly) begin
         tick(1);
         chk_eq("req_held", int'(cfg_req), 1);
         chk_eq("mode_stable", int'(cfg_mode), exp_mode);
      end
      cfg_ack = 1'b1;
      tick(1);
      cfg_ack = 1'b0;
      chk_eq("req_clr_after_ack", int'(cfg_req), 0);
      chk_eq("busy_in_wait", int'(busy), 1);
      repeat (done_dly - 1) tick(1);
      chk_eq("mode_in_wait", int'(cfg_mode), exp_mode);
      cfg_done = 1'b1;
      cfg_fail = fail;
      tick(1);
      cfg_done = 1'b0;
      cfg_fail = 1'b0;
   endtask

   task automatic do_press();
      press = 1'b1;
      tick(1);
      press = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick(3);
      chk_eq("rst_req", int'(cfg_req), 0);
      chk_eq("rst_mode", int'(cfg_mode), 0);
      chk_eq("rst_active", int'(active_mode), 0);
      chk_eq("rst_busy", int'(busy), 0);
      chk_eq("rst_err", int'(cfg_error), 0);
      chk_eq("rst_drop", int'(press_dropped), 0);

      // 1: initial request of START_MODE
      reset = 1'b0;
      exp_q.push_back(0);
      tick(1);
      chk_eq("init_req", int'(cfg_req), 1);
      chk_eq("init_busy", int'(busy), 1);
      serve(2, 5, 1'b0, 0);
      chk_eq("init_active", int'(active_mode), 0);
      chk_eq("init_busy_fall", int'(busy), 0);
      chk_eq("init_err", int'(cfg_error), 0);

      // 2: three steps with wrap
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(nxt(m_active));
         do_press();
         chk_eq("step_req", int'(cfg_req), 1);
         serve(1, 2, 1'b0, nxt(m_active));
         m_active = nxt(m_active);
         chk_eq("step_active", int'(active_mode), m_active);
         chk_eq("step_idle", int'(busy), 0);
      end

      // 3: one pending press, two dropped
      drop_base = drop_cnt;
      exp_q.push_back(nxt(m_active));
      do_press();
      cfg_ack = 1'b1;
      tick(1);
      cfg_ack = 1'b0;
      exp_q.push_back(nxt(nxt(m_active)));
      for (int i = 0; i < 3; i++) begin
         do_press();
         tick(1);
      end
      chk_eq("drop_count", drop_cnt - drop_base, 2);
      cfg_done = 1'b1;
      tick(1);
      cfg_done = 1'b0;
      chk_eq("relaunch_req", int'(cfg_req), 1);
      chk_eq("relaunch_mode", int'(cfg_mode), nxt(nxt(m_active)));
      chk_eq("relaunch_active", int'(active_mode), nxt(m_active));
      chk_eq("relaunch_busy", int'(busy), 1);
      serve(1, 1, 1'b0, nxt(nxt(m_active)));
      m_active = nxt(nxt(m_active));
      chk_eq("pend_final_active", int'(active_mode), m_active);
      chk_eq("pend_final_idle", int'(busy), 0);

      // 4: timeout after ack with no done
      exp_q.push_back(nxt(m_active));
      do_press();
      cfg_ack = 1'b1;
      tick(1);
      cfg_ack = 1'b0;
      tick(14);
      chk_eq("to_still_busy", int'(busy), 1);
      tick(1);
      chk_eq("to_req", int'(cfg_req), 0);
      chk_eq("to_busy", int'(busy), 0);
      chk_eq("to_err", int'(cfg_error), 1);
      chk_eq("to_active", int'(active_mode), m_active);
      exp_q.push_back(nxt(m_active));
      do_press();
      serve(1, 2, 1'b0, nxt(m_active));
      m_active = nxt(m_active);
      chk_eq("to_recover_err", int'(cfg_error), 0);
      chk_eq("to_recover_active", int'(active_mode), m_active);

      // 5: failure with a press pending
      exp_q.push_back(nxt(m_active));
      do_press();
      cfg_ack = 1'b1;
      tick(1);
      cfg_ack = 1'b0;
      do_press();
      cfg_done = 1'b1;
      cfg_fail = 1'b1;
      tick(1);
      cfg_done = 1'b0;
      cfg_fail = 1'b0;
      chk_eq("fail_err", int'(cfg_error), 1);
      chk_eq("fail_active", int'(active_mode), m_active);
      chk_eq("fail_busy", int'(busy), 0);
      tick(3);
      chk_eq("fail_no_relaunch", int'(cfg_req), 0);

      // 6: reset in WAIT with cfg_mode=2, then stray done/ack in IDLE
      exp_q.push_back(nxt(m_active));
      do_press();
      serve(1, 1, 1'b0, nxt(m_active));
      m_active = nxt(m_active);
      exp_q.push_back(nxt(m_active));
      do_press();
      cfg_ack = 1'b1;
      tick(1);
      cfg_ack = 1'b0;
      do_press();
      chk_eq("pre_rst_mode", int'(cfg_mode), 2);
      reset = 1'b1;
      tick(1);
      chk_eq("mid_rst_req", int'(cfg_req), 0);
      chk_eq("mid_rst_active", int'(active_mode), 0);
      chk_eq("mid_rst_busy", int'(busy), 0);
      m_active = 0;
      reset = 1'b0;
      exp_q.push_back(0);
      tick(1);
      chk_eq("reinit_req", int'(cfg_req), 1);
      chk_eq("reinit_mode", int'(cfg_mode), 0);
      serve(1, 1, 1'b0, 0);
      chk_eq("reinit_idle", int'(busy), 0);
      tick(2);
      chk_eq("reinit_no_pending", int'(cfg_req), 0);
      cfg_done = 1'b1;
      cfg_fail = 1'b1;
      cfg_ack  = 1'b1;
      tick(1);
      cfg_done = 1'b0;
      cfg_fail = 1'b0;
      cfg_ack  = 1'b0;
      tick(1);
      chk_eq("stray_err", int'(cfg_error), 0);
      chk_eq("stray_active", int'(active_mode), 0);
      chk_eq("stray_busy", int'(busy), 0);
      chk_eq("stray_req", int'(cfg_req), 0);
      chk_eq("sb_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
